alu_bitserial: RTL and testbench

ALU_BITSERIAL -- requirements
Module: alu_bitserial

---
 rtl/alu_bitserial.sv | 197 +++++++++++++++++++
 tb/tb_alu_bitserial.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bitserial.sv
// -----------------------------------------------------------------------------
// alu_bitserial
//
// Sequencer that runs a WIDTH-bit operation through an external 1-bit ALU
// slice, one bit per clock, LSB first. The slice's select code is passed
// through unchanged. Its carry output is registered so that bit k+1 sees the
// carry produced by bit k.
//
// Handshake:
//   ready is high in IDLE and DONE. A start seen with ready=1 at a rising
//   edge is accepted there: the operands, select and carry_in are captured,
//   and the FSM enters RUN. start is ignored while busy=1. done pulses for
//   the single cycle after the last bit edge. result, carry_out (and
//   overflow) are then held until the next accepted start.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   start / ready       request / accept-able
//   op_a, op_b          WIDTH-bit operands
//   select, carry_in    slice opcode and carry into bit 0
//   slice_a, slice_b, slice_carry_in, slice_select   drive the 1-bit slice
//   slice_out, slice_carry_out                       returned by the slice
//   busy, done          RUN indicator, one-cycle completion pulse
//   result, carry_out   assembled result, carry out of bit WIDTH-1
//   dbg_state           current FSM state (0=IDLE, 1=RUN, 2=DONE)
//   overflow            only with ALU_BITSERIAL_OVF_EN: carry into bit
//                       WIDTH-1 XOR carry out of bit WIDTH-1
//
// Optional feature macro: ALU_BITSERIAL_OVF_EN
// -----------------------------------------------------------------------------
module alu_bitserial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       select,
  input  logic             carry_in,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_carry_in,
  output logic [2:0]       slice_select,
  input  logic             slice_out,
  input  logic             slice_carry_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [1:0]       dbg_state
`ifdef ALU_BITSERIAL_OVF_EN
  ,
  output logic             overflow
`endif
);

  // The counter reaches WIDTH exactly once, at the last bit edge, and then
  // stops because the FSM leaves RUN.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_sel;
  logic             r_cin;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
`ifdef ALU_BITSERIAL_OVF_EN
  logic             r_ovf;
`endif

  logic             w_run;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_bit_mask;
  logic             w_slice_cin;

  assign w_run      = (r_state == S_RUN);
  // A start is accepted whenever the FSM is not running.
  assign w_accept   = start && !w_run;
  assign w_last     = w_run && (r_cnt == CW'(WIDTH - 1));
  // One-hot selector of the bit being processed this cycle.
  assign w_bit_mask = WIDTH'(1) << r_cnt;

  // Bit 0 takes the captured carry_in; later bits take the carry the slice
  // produced for the previous bit.
  assign w_slice_cin = (r_cnt == '0) ? r_cin : r_carry;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    ready          = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    slice_a        = 1'b0;
    slice_b        = 1'b0;
    slice_carry_in = 1'b0;
    slice_select   = 3'b000;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy           = 1'b1;
        slice_a        = |(r_a & w_bit_mask);
        slice_b        = |(r_b & w_bit_mask);
        slice_carry_in = w_slice_cin;
        slice_select   = r_sel;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        ready       = 1'b1;
        done        = 1'b1;
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand capture, bit counter and result assembly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_sel       <= 3'b000;
      r_cin       <= 1'b0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
`ifdef ALU_BITSERIAL_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a      <= op_a;
      r_b      <= op_b;
      r_sel    <= select;
      r_cin    <= carry_in;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
    end else if (w_run) begin
      r_result <= (r_result & ~w_bit_mask) | ({WIDTH{slice_out}} & w_bit_mask);
      r_carry  <= slice_carry_out;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_carry_out <= slice_carry_out;
`ifdef ALU_BITSERIAL_OVF_EN
        // Carry into the MSB is what the slice is seeing right now.
        r_ovf       <= w_slice_cin ^ slice_carry_out;
`endif
      end
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign dbg_state = r_state;
`ifdef ALU_BITSERIAL_OVF_EN
  assign overflow  = r_ovf;
`endif

endmodule

// File: tb/tb_alu_bitserial.sv
// -----------------------------------------------------------------------------
// tb_alu_bitserial
//
// Bench for alu_bitserial with WIDTH=4. A behavioural 1-bit slice
// (select 000 = AND, 001 = full add) is attached to the slice pins. Expected
// {overflow, carry, result} words are pushed to exp_q when a start is
// accepted, and they are popped when done is seen. Inputs change 1 time unit
// after a rising edge. Outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_alu_bitserial;

  localparam int WIDTH = 4;
  localparam int EW    = WIDTH + 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       select;
  logic             carry_in;
  logic             slice_a;
  logic             slice_b;
  logic             slice_carry_in;
  logic [2:0]       slice_select;
  logic             slice_out;
  logic             slice_carry_out;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic [1:0]       dbg_state;
`ifdef ALU_BITSERIAL_OVF_EN
  logic             overflow;
`endif

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  alu_bitserial #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .ready           (ready),
    .op_a            (op_a),
    .op_b            (op_b),
    .select          (select),
    .carry_in        (carry_in),
    .slice_a         (slice_a),
    .slice_b         (slice_b),
    .slice_carry_in  (slice_carry_in),
    .slice_select    (slice_select),
    .slice_out       (slice_out),
    .slice_carry_out (slice_carry_out),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .carry_out       (carry_out),
    .dbg_state       (dbg_state)
`ifdef ALU_BITSERIAL_OVF_EN
    ,
    .overflow        (overflow)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Behavioural 1-bit slice
  // ---------------------------------------------------------------------------
  always_comb begin
    slice_out       = 1'b0;
    slice_carry_out = 1'b0;
    case (slice_select)
      3'b000: slice_out = slice_a & slice_b;
      3'b001: begin
        slice_out       = slice_a ^ slice_b ^ slice_carry_in;
        slice_carry_out = (slice_a & slice_b) | (slice_a & slice_carry_in) |
                          (slice_b & slice_carry_in);
      end
      default: ;
    endcase
  end

  // Word-level reference: returns {overflow, carry_out, result}.
  function automatic logic [EW-1:0] model_op(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0] sel,
                                             input logic cin);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             o;
    r = '0;
    c = 1'b0;
    o = 1'b0;
    if (sel == 3'b001) begin
      sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      r   = sum[WIDTH-1:0];
      c   = sum[WIDTH];
      o   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end else if (sel == 3'b000) begin
      r = a & b;
    end
    return {o, c, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // One full operation. The caller must be at edge+1 with the DUT ready.
  // This task checks the slice pins on every RUN cycle, the done latency, the
  // scoreboard result and the done pulse width.
  // ---------------------------------------------------------------------------
  task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [2:0] sel,
                        input logic cin, output logic [EW-1:0] got);
    logic       c;
    logic [6:0] exp_pins;
    logic [6:0] obs_pins;
    logic [EW-1:0] e;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_start: got %b expected 1", name, ready);
    end
    op_a = a; op_b = b; select = sel; carry_in = cin; start = 1'b1;
    tick();                               // edge 0: accepted
    start = 1'b0;
    exp_q.push_back(model_op(a, b, sel, cin));
    c = cin;
    for (int k = 0; k < WIDTH; k++) begin
      // Scramble the live operand inputs; the captured copy must be used.
      op_a = WIDTH'($urandom); op_b = WIDTH'($urandom);
      select = 3'($urandom); carry_in = 1'($urandom);
      exp_pins = {1'b1, a[k], b[k], c, sel};
      obs_pins = {busy, slice_a, slice_b, slice_carry_in, slice_select};
      checks++;
      if (obs_pins !== exp_pins) begin
        errors++;
        $display("FAIL %s run_cycle%0d {busy,a,b,cin,sel}: got %b expected %b",
                 name, k, obs_pins, exp_pins);
      end
      c = (sel == 3'b001) ? ((a[k] & b[k]) | (a[k] & c) | (b[k] & c)) : 1'b0;
      tick();
    end
    // After edge WIDTH the result is ready.
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done_latency: done=%b expected 1 after edge %0d", name, done, WIDTH);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    got = e;
    checks++;
    if ({carry_out, result} !== e[WIDTH:0]) begin
      errors++;
      $display("FAIL %s result: got c=%b r=%h expected c=%b r=%h",
               name, carry_out, result, e[WIDTH], e[WIDTH-1:0]);
    end
`ifdef ALU_BITSERIAL_OVF_EN
    checks++;
    if (overflow !== e[WIDTH+1]) begin
      errors++;
      $display("FAIL %s overflow: got %b expected %b", name, overflow, e[WIDTH+1]);
    end
`endif
    tick();
    checks++;
    if ({done, ready, busy, slice_a, slice_b, slice_carry_in, slice_select} !== 9'b0_1_0_0_0_0_000) begin
      errors++;
      $display("FAIL %s after_done {done,ready,busy,pins}: got %b expected 010000000",
               name, {done, ready, busy, slice_a, slice_b, slice_carry_in, slice_select});
    end
    checks++;
    if ({carry_out, result} !== e[WIDTH:0]) begin
      errors++;
      $display("FAIL %s result_hold: got c=%b r=%h expected c=%b r=%h",
               name, carry_out, result, e[WIDTH], e[WIDTH-1:0]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    op_a = '1; op_b = '1; select = 3'b001; carry_in = 1'b1;
    #2;
    checks++;
    if ({ready, busy, done, result, carry_out, dbg_state} !== {3'b100, {WIDTH{1'b0}}, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state {ready,busy,done,result,carry,state}: got %b expected %b",
               {ready, busy, done, result, carry_out, dbg_state},
               {3'b100, {WIDTH{1'b0}}, 1'b0, 2'd0});
    end
    tick(); tick();
    checks++;
    if ({slice_a, slice_b, slice_carry_in, slice_select} !== 6'b0) begin
      errors++;
      $display("FAIL reset_slice_pins: got %b expected 000000",
               {slice_a, slice_b, slice_carry_in, slice_select});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_and();
    logic [EW-1:0] got;
    run_op("and", 4'b1100, 4'b1010, 3'b000, 1'b0, got);
    checks++;
    if (result !== 4'b1000) begin
      errors++;
      $display("FAIL and_const: got %b expected 1000", result);
    end
  endtask

  task automatic test_add();
    logic [EW-1:0] got;
    run_op("add", 4'd7, 4'd9, 3'b001, 1'b0, got);
    checks++;
    if ({carry_out, result} !== 5'b1_0000) begin
      errors++;
      $display("FAIL add_const: got c=%b r=%h expected c=1 r=0", carry_out, result);
    end
  endtask

  task automatic test_carry_chain();
    logic [EW-1:0] got;
    // The per-cycle pin check in run_op expects slice_carry_in=1 in every RUN cycle.
    run_op("carry_chain", 4'hF, 4'h0, 3'b001, 1'b1, got);
    checks++;
    if ({carry_out, result} !== 5'b1_0000) begin
      errors++;
      $display("FAIL carry_chain_const: got c=%b r=%h expected c=1 r=0", carry_out, result);
    end
  endtask

  task automatic test_overflow();
`ifdef ALU_BITSERIAL_OVF_EN
    logic [EW-1:0] got;
    run_op("ovf", 4'd7, 4'd1, 3'b001, 1'b0, got);
    checks++;
    if ({overflow, carry_out, result} !== 6'b1_0_1000) begin
      errors++;
      $display("FAIL ovf_const: got o=%b c=%b r=%h expected o=1 c=0 r=8",
               overflow, carry_out, result);
    end
    run_op("ovf_add", 4'd7, 4'd9, 3'b001, 1'b0, got);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_add_const: got %b expected 0", overflow);
    end
`endif
  endtask

  task automatic test_random();
    logic [EW-1:0] got;
    for (int i = 0; i < 8; i++) begin
      run_op("random", WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)),
             3'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
    end
  endtask

  task automatic test_back_to_back();
    logic [EW-1:0] e;
    int n;
    op_a = 4'b0110; op_b = 4'b0011; select = 3'b000; carry_in = 1'b0; start = 1'b1;
    tick();                               // edge 0
    start = 1'b0;
    exp_q.push_back(model_op(4'b0110, 4'b0011, 3'b000, 1'b0));
    tick(); tick();                       // RUN cycle 2
    op_a = 4'hF; op_b = 4'hF; select = 3'b001; carry_in = 1'b1; start = 1'b1;
    tick();                               // edge 3: must be ignored
    start = 1'b0;
    checks++;
    if ({busy, dbg_state} !== {1'b1, 2'd1}) begin
      errors++;
      $display("FAIL b2b_start_ignored {busy,state}: got %b expected 101", {busy, dbg_state});
    end
    tick();                               // edge 4
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: got %b expected 1", done);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if ({carry_out, result} !== e[WIDTH:0]) begin
      errors++;
      $display("FAIL b2b_first_result: got c=%b r=%h expected c=%b r=%h",
               carry_out, result, e[WIDTH], e[WIDTH-1:0]);
    end
    // Start during DONE is accepted on the next edge.
    op_a = 4'd5; op_b = 4'd6; select = 3'b001; carry_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(model_op(4'd5, 4'd6, 3'b001, 1'b1));
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL b2b_second_done_gap: got %0d edges expected 5", n);
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if ({carry_out, result} !== e[WIDTH:0]) begin
      errors++;
      $display("FAIL b2b_second_result: got c=%b r=%h expected c=%b r=%h",
               carry_out, result, e[WIDTH], e[WIDTH-1:0]);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [EW-1:0] got;
    int seen_done;
    op_a = 4'hA; op_b = 4'h5; select = 3'b001; carry_in = 1'b1; start = 1'b1;
    tick();                               // edge 0
    start = 1'b0;
    exp_q.push_back(model_op(4'hA, 4'h5, 3'b001, 1'b1));
    tick(); tick();                       // RUN cycle 2
    rst_n = 1'b0;
    #1;
    exp_q.delete();                       // aborted operation produces nothing
    checks++;
    if ({ready, busy, done, result, carry_out, dbg_state} !== {3'b100, {WIDTH{1'b0}}, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL rst_mid_run_state {ready,busy,done,result,carry,state}: got %b expected %b",
               {ready, busy, done, result, carry_out, dbg_state},
               {3'b100, {WIDTH{1'b0}}, 1'b0, 2'd0});
    end
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL rst_mid_run_no_done: got %0d done cycles expected 0", seen_done);
    end
    rst_n = 1'b1;
    // First edge after release must accept a start.
    run_op("after_reset", 4'd3, 4'd4, 3'b001, 1'b0, got);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_and();
    test_add();
    test_carry_chain();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
